// File: rtl/fpu_ss_pkg.sv
// fpu_ss_pkg: shared types and constants for the FPU subsystem issue control.
package fpu_ss_pkg;
  localparam int CNT_W = 4;
  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_FPU  = 2'd1,
    FWD_LSU  = 2'd2
  } fwd_sel_e;
  function automatic logic [31:0] reg_onehot(input logic [4:0] r);
    return 32'(1) << r;
  endfunction
endpackage

// File: rtl/fpu_ss_id_table.sv
// fpu_ss_id_table: per-offload-ID committed/killed flags; a clear beats a same-cycle set.
module fpu_ss_id_table #(
  parameter int ID_WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                set_valid,
  input  logic                set_kill,
  input  logic [ID_WIDTH-1:0] set_id,
  input  logic                clr_valid,
  input  logic [ID_WIDTH-1:0] clr_id,
  input  logic [ID_WIDTH-1:0] query_id,
  output logic                query_committed,
  output logic                query_killed
);
  localparam int N = 2 ** ID_WIDTH;
  logic [N-1:0] committed_q;
  logic [N-1:0] killed_q;
  // record commits/kills; retiring an entry wipes both flags so a bypassed commit is consumed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      committed_q <= '0;
      killed_q    <= '0;
    end else begin
      if (set_valid && !set_kill) committed_q[set_id] <= 1'b1;
      if (set_valid && set_kill) killed_q[set_id] <= 1'b1;
      if (clr_valid) begin
        committed_q[clr_id] <= 1'b0;
        killed_q[clr_id]    <= 1'b0;
      end
    end
  end
  assign query_committed = committed_q[query_id];
  assign query_killed    = killed_q[query_id];
endmodule

// File: rtl/fpu_ss_issue_ctrl.sv
// fpu_ss_issue_ctrl: issue/dispatch control with scoreboard and credit counter; FPU_SS_FORWARDING_EN enables write-back forwarding.
module fpu_ss_issue_ctrl
  import fpu_ss_pkg::*;
#(
  parameter int ID_WIDTH     = 4,
  parameter int MAX_INFLIGHT = 4,
  parameter bit OUT_OF_ORDER = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  iss_valid_i,
  output logic                  iss_ready_o,
  input  logic [ID_WIDTH-1:0]   iss_id_i,
  input  logic [4:0]            iss_rd_i,
  input  logic                  iss_rd_fp_i,
  input  logic [2:0][4:0]       iss_rs_i,
  input  logic [2:0]            iss_rs_used_i,
  input  logic                  iss_is_mem_i,
  input  logic                  iss_is_load_i,
  input  logic                  commit_valid_i,
  input  logic                  commit_kill_i,
  input  logic [ID_WIDTH-1:0]   commit_id_i,
  output logic                  fpu_in_valid_o,
  input  logic                  fpu_in_ready_i,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  input  logic                  fpu_wb_valid_i,
  output logic                  fpu_wb_ready_o,
  input  logic [4:0]            fpu_wb_rd_i,
  input  logic                  fpu_wb_fp_i,
  input  logic                  lsu_wb_valid_i,
  input  logic [4:0]            lsu_wb_rd_i,
  input  logic                  lsu_wb_we_i,
  output logic                  fpr_we_o,
  output logic [4:0]            fpr_waddr_o,
  output logic [2:0][1:0]       fwd_sel_o,
  output logic [CNT_W-1:0]      inflight_cnt_o,
  output logic                  busy_o
);
  logic [31:0]      pending_q;
  logic [CNT_W-1:0] cnt_q;
  logic             live;
  logic             lsu_acc;
  logic             fpu_acc;
  logic             wb_any;
  logic             lsu_fpr;
  logic             fpu_fpr;
  logic             tbl_committed;
  logic             head_killed;
  logic             commit_hit;
  logic             head_drop;
  logic             rs_hazard;
  logic             rd_hazard;
  logic             credit_ok;
  logic             order_ok;
  logic             eligible;
  logic             fpu_hs;
  logic             mem_hs;
  logic             dispatch;
  logic [31:0]      pend_set;
  logic [31:0]      pend_clr;

  // every combinational output is forced low while reset is asserted
  assign live           = ~rst_i;
  assign fpu_wb_ready_o = live & ~lsu_wb_valid_i;
  assign lsu_acc        = live & lsu_wb_valid_i;
  assign fpu_acc        = fpu_wb_valid_i & fpu_wb_ready_o;
  assign wb_any         = lsu_acc | fpu_acc;
  assign lsu_fpr        = lsu_acc & lsu_wb_we_i;
  assign fpu_fpr        = fpu_acc & fpu_wb_fp_i;
  assign fpr_we_o       = lsu_fpr | fpu_fpr;
  assign fpr_waddr_o    = lsu_fpr ? lsu_wb_rd_i : fpu_fpr ? fpu_wb_rd_i : 5'd0;

  fpu_ss_id_table #(.ID_WIDTH(ID_WIDTH)) u_id_table (
    .clk            (clk_i),
    .rst            (rst_i),
    .set_valid      (commit_valid_i),
    .set_kill       (commit_kill_i),
    .set_id         (commit_id_i),
    .clr_valid      (iss_ready_o),
    .clr_id         (iss_id_i),
    .query_id       (iss_id_i),
    .query_committed(tbl_committed),
    .query_killed   (head_killed)
  );

  // per-operand forwarding from the write-back currently hitting the register file
  always_comb begin
    for (int k = 0; k < 3; k++) begin
`ifdef FPU_SS_FORWARDING_EN
      fwd_sel_o[k] = !(live && iss_rs_used_i[k]) ? FWD_NONE :
                     (lsu_fpr && lsu_wb_rd_i == iss_rs_i[k]) ? FWD_LSU :
                     (fpu_fpr && fpu_wb_rd_i == iss_rs_i[k]) ? FWD_FPU : FWD_NONE;
`else
      fwd_sel_o[k] = FWD_NONE;
`endif
    end
  end

  // a pending source only blocks when it is not being forwarded this cycle
  always_comb begin
    rs_hazard = 1'b0;
    for (int k = 0; k < 3; k++)
      rs_hazard = rs_hazard | (iss_rs_used_i[k] & pending_q[iss_rs_i[k]] & (fwd_sel_o[k] == FWD_NONE));
  end

  assign rd_hazard       = iss_rd_fp_i & pending_q[iss_rd_i] & ~(fpr_we_o & (fpr_waddr_o == iss_rd_i));
  assign commit_hit      = commit_valid_i & ~commit_kill_i & (commit_id_i == iss_id_i);
  assign head_drop       = live & iss_valid_i & head_killed;
  assign credit_ok       = cnt_q < CNT_W'(MAX_INFLIGHT);
  assign order_ok        = OUT_OF_ORDER || (cnt_q == '0) || wb_any;
  assign eligible        = live & iss_valid_i & (tbl_committed | commit_hit) & ~head_killed &
                           ~rs_hazard & ~rd_hazard & credit_ok & order_ok;
  assign fpu_in_valid_o  = eligible & ~iss_is_mem_i;
  assign mem_req_valid_o = eligible & iss_is_mem_i;
  assign fpu_hs          = fpu_in_valid_o & fpu_in_ready_i;
  assign mem_hs          = mem_req_valid_o & mem_req_ready_i;
  assign dispatch        = fpu_hs | mem_hs;
  assign iss_ready_o     = dispatch | head_drop;
  assign pend_set        = ((fpu_hs & iss_rd_fp_i) | (mem_hs & iss_is_load_i)) ? reg_onehot(iss_rd_i) : '0;
  assign pend_clr        = fpr_we_o ? reg_onehot(fpr_waddr_o) : '0;
  assign inflight_cnt_o  = cnt_q;
  assign busy_o          = |cnt_q;

  // scoreboard and in-flight credit; stale write-backs at zero never wrap the counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_q <= '0;
      cnt_q     <= '0;
    end else begin
      pending_q <= (pending_q & ~pend_clr) | pend_set;
      cnt_q     <= (dispatch == wb_any) ? cnt_q :
                   dispatch ? cnt_q + CNT_W'(1) :
                   (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
    end
  end
endmodule

// File: tb/tb_fpu_ss_issue_ctrl.sv
// tb_fpu_ss_issue_ctrl: directed checks of issue control with MAX_INFLIGHT=2.
module tb_fpu_ss_issue_ctrl;
  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            iss_valid, iss_ready, iss_rd_fp, iss_is_mem, iss_is_load;
  logic [3:0]      iss_id, commit_id, inflight_cnt;
  logic [4:0]      iss_rd, fpu_wb_rd, lsu_wb_rd, fpr_waddr;
  logic [2:0][4:0] iss_rs;
  logic [2:0]      iss_rs_used;
  logic            commit_valid, commit_kill;
  logic            fpu_in_valid, fpu_in_ready, mem_req_valid, mem_req_ready;
  logic            fpu_wb_valid, fpu_wb_ready, fpu_wb_fp;
  logic            lsu_wb_valid, lsu_wb_we, fpr_we, busy;
  logic [2:0][1:0] fwd_sel;
  int              n_chk = 0;
  int              n_pass = 0;

  always #5 clk_i = ~clk_i;

  fpu_ss_issue_ctrl #(.ID_WIDTH(4), .MAX_INFLIGHT(2), .OUT_OF_ORDER(1'b1)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .iss_valid_i(iss_valid), .iss_ready_o(iss_ready), .iss_id_i(iss_id),
    .iss_rd_i(iss_rd), .iss_rd_fp_i(iss_rd_fp), .iss_rs_i(iss_rs), .iss_rs_used_i(iss_rs_used),
    .iss_is_mem_i(iss_is_mem), .iss_is_load_i(iss_is_load),
    .commit_valid_i(commit_valid), .commit_kill_i(commit_kill), .commit_id_i(commit_id),
    .fpu_in_valid_o(fpu_in_valid), .fpu_in_ready_i(fpu_in_ready),
    .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready),
    .fpu_wb_valid_i(fpu_wb_valid), .fpu_wb_ready_o(fpu_wb_ready), .fpu_wb_rd_i(fpu_wb_rd),
    .fpu_wb_fp_i(fpu_wb_fp), .lsu_wb_valid_i(lsu_wb_valid), .lsu_wb_rd_i(lsu_wb_rd),
    .lsu_wb_we_i(lsu_wb_we), .fpr_we_o(fpr_we), .fpr_waddr_o(fpr_waddr),
    .fwd_sel_o(fwd_sel), .inflight_cnt_o(inflight_cnt), .busy_o(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    iss_valid = 0; iss_id = 0; iss_rd = 0; iss_rd_fp = 0; iss_rs = '0; iss_rs_used = '0;
    iss_is_mem = 0; iss_is_load = 0; commit_valid = 0; commit_kill = 0; commit_id = 0;
    fpu_in_ready = 0; mem_req_ready = 0; fpu_wb_valid = 0; fpu_wb_rd = 0; fpu_wb_fp = 0;
    lsu_wb_valid = 0; lsu_wb_rd = 0; lsu_wb_we = 0;
  endtask

  task automatic head(input logic [3:0] id, input logic [4:0] rd, input logic mem, input logic load);
    iss_valid = 1; iss_id = id; iss_rd = rd; iss_rd_fp = 1; iss_is_mem = mem; iss_is_load = load;
    iss_rs = '0; iss_rs_used = '0; fpu_in_ready = 1; mem_req_ready = 1;
  endtask

  task automatic commit(input logic [3:0] id, input logic kill);
    commit_valid = 1; commit_kill = kill; commit_id = id;
  endtask

  task automatic fpu_wb(input logic [4:0] rd);
    fpu_wb_valid = 1; fpu_wb_rd = rd; fpu_wb_fp = 1;
  endtask

  initial begin
    idle();
    rst_i = 1;
    head(3, 1, 0, 0); commit(3, 0); fpu_wb(4);
    step();
    chk("rst_wb_ready", fpu_wb_ready, 0);
    chk("rst_iss_ready", iss_ready, 0);
    chk("rst_fpu_valid", fpu_in_valid, 0);
    chk("rst_fpr_we", fpr_we, 0);
    chk("rst_cnt", inflight_cnt, 0);
    chk("rst_busy", busy, 0);
    idle(); rst_i = 0;
    step();
    // commit bypass
    head(3, 1, 0, 0); #1;
    chk("nocommit_valid", fpu_in_valid, 0);
    chk("nocommit_ready", iss_ready, 0);
    commit(3, 0); #1;
    chk("bypass_valid", fpu_in_valid, 1);
    chk("bypass_ready", iss_ready, 1);
    chk("bypass_mem", mem_req_valid, 0);
    step(); idle(); #1;
    chk("cnt_after_1", inflight_cnt, 1);
    chk("busy_after_1", busy, 1);
    head(3, 2, 0, 0); #1;
    chk("commit_consumed", fpu_in_valid, 0);
    idle(); fpu_wb(1); #1;
    chk("wb_ready", fpu_wb_ready, 1);
    chk("wb_we", fpr_we, 1);
    chk("wb_addr", fpr_waddr, 1);
    step(); idle(); #1;
    chk("cnt_after_wb", inflight_cnt, 0);
    chk("busy_after_wb", busy, 0);
    // killed head drop
    commit(5, 1); step(); idle();
    head(5, 3, 1, 1); #1;
    chk("kill_ready", iss_ready, 1);
    chk("kill_fpu", fpu_in_valid, 0);
    chk("kill_mem", mem_req_valid, 0);
    chk("kill_cnt", inflight_cnt, 0);
    step();
    chk("kill_cleared", iss_ready, 0);
    chk("kill_cnt_after", inflight_cnt, 0);
    idle();
    // credit cap at 2
    commit(1, 0); step(); commit(2, 0); step(); commit(6, 0); step(); idle();
    head(1, 10, 0, 0); #1;
    chk("d1_valid", fpu_in_valid, 1);
    step(); idle();
    head(2, 11, 1, 1); #1;
    chk("d2_mem", mem_req_valid, 1);
    chk("d2_fpu", fpu_in_valid, 0);
    step(); idle();
    head(6, 12, 0, 0); #1;
    chk("cap_cnt", inflight_cnt, 2);
    chk("cap_stall", fpu_in_valid, 0);
    step();
    chk("cap_stall2", iss_ready, 0);
    fpu_wb(10); #1;
    chk("credit_same_cycle", fpu_in_valid, 0);
    step(); fpu_wb_valid = 0; #1;
    chk("cap_cnt_1", inflight_cnt, 1);
    chk("refill_valid", fpu_in_valid, 1);
    chk("refill_ready", iss_ready, 1);
    step(); idle(); #1;
    chk("refill_cnt", inflight_cnt, 2);
    // forwarding of a pending source
    lsu_wb_valid = 1; lsu_wb_rd = 11; lsu_wb_we = 1;
    step(); idle(); #1;
    chk("lsu_wb_cnt", inflight_cnt, 1);
    head(7, 13, 0, 0); commit(7, 0); iss_rs[0] = 12; iss_rs_used = 3'b001; #1;
    chk("raw_stall", fpu_in_valid, 0);
    fpu_wb(12); #1;
`ifdef FPU_SS_FORWARDING_EN
    chk("fwd_sel", fwd_sel[0], 1);
    chk("fwd_dispatch", fpu_in_valid, 1);
    step(); idle(); #1;
    chk("fwd_cnt", inflight_cnt, 1);
`else
    chk("nofwd_sel", fwd_sel[0], 0);
    chk("nofwd_stall", fpu_in_valid, 0);
    step(); fpu_wb_valid = 0; commit_valid = 0; #1;
    chk("nofwd_dispatch", fpu_in_valid, 1);
    chk("nofwd_cnt0", inflight_cnt, 0);
    step(); idle(); #1;
    chk("nofwd_cnt", inflight_cnt, 1);
`endif
    // destination hazard and same-cycle set beating clear
    head(8, 13, 0, 0); commit(8, 0); #1;
    chk("waw_stall", fpu_in_valid, 0);
    fpu_wb(13); #1;
    chk("waw_clear", fpu_in_valid, 1);
    chk("waw_waddr", fpr_waddr, 13);
    step(); idle(); #1;
    chk("waw_cnt", inflight_cnt, 1);
    head(9, 13, 0, 0); commit(9, 0); #1;
    chk("set_wins", fpu_in_valid, 0);
    step(); idle();
    // simultaneous write-backs, LSU first
    fpu_wb(7); lsu_wb_valid = 1; lsu_wb_rd = 9; lsu_wb_we = 1; #1;
    chk("both_wb_ready", fpu_wb_ready, 0);
    chk("both_waddr", fpr_waddr, 9);
    chk("both_we", fpr_we, 1);
    step(); lsu_wb_valid = 0; #1;
    chk("both_cnt", inflight_cnt, 0);
    chk("second_ready", fpu_wb_ready, 1);
    chk("second_waddr", fpr_waddr, 7);
    step(); idle(); #1;
    chk("no_underflow", inflight_cnt, 0);
    fpu_wb(13); step(); idle();
    head(9, 13, 0, 0); #1;
    chk("pending_cleared", fpu_in_valid, 1);
    step(); idle();
    // reset with work in flight
    commit(11, 0); step(); idle();
    head(10, 14, 0, 0); commit(10, 0); #1;
    chk("g_dispatch", fpu_in_valid, 1);
    step(); idle(); #1;
    chk("g_cnt", inflight_cnt, 2);
    lsu_wb_valid = 1; lsu_wb_rd = 20; lsu_wb_we = 1; fpu_wb(14);
    rst_i = 1; #1;
    chk("mid_rst_cnt", inflight_cnt, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_wb_ready", fpu_wb_ready, 0);
    chk("mid_rst_we", fpr_we, 0);
    chk("mid_rst_waddr", fpr_waddr, 0);
    chk("mid_rst_ready", iss_ready, 0);
    chk("mid_rst_fwd", fwd_sel, 0);
    step(); idle(); rst_i = 0;
    step();
    head(11, 15, 0, 0); #1;
    chk("commit_flushed", fpu_in_valid, 0);
    idle(); fpu_wb(14);
    step(); idle(); #1;
    chk("stale_wb", inflight_cnt, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fpu_ss_issue_ctrl.md
FPU_SS_ISSUE_CTRL -- requirements
Module: fpu_ss_issue_ctrl

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 4, meaning offload-ID width; the ID table has 2**ID_WIDTH entries.
REQ-002 SHALL have parameter MAX_INFLIGHT, default 4, range 1..15, meaning the cap on dispatched-but-not-written-back instructions.
REQ-003 SHALL have parameter OUT_OF_ORDER, default 1; 0 means dispatch only when nothing is in flight.
REQ-004 Ports SHALL be (name direction width meaning):
 clk_i  in  1  clock; the only clock.
 rst_i  in  1  reset, asynchronous, active-high.
 iss_valid_i/iss_ready_o  in/out  1  issue-buffer head handshake.
 iss_id_i  in  ID_WIDTH  head instruction ID.
 iss_rd_i  in  5  destination register; iss_rd_fp_i  in  1  rd is an FP register.
 iss_rs_i  in  3x5  source FP registers; iss_rs_used_i  in  3  per-operand valid.
 iss_is_mem_i  in  1  head is a load/store; iss_is_load_i  in  1  head is a load.
 commit_valid_i, commit_kill_i  in  1 each; commit_id_i  in  ID_WIDTH  commit interface.
 fpu_in_valid_o/fpu_in_ready_i  out/in  1  FPU dispatch handshake.
 mem_req_valid_o/mem_req_ready_i  out/in  1  memory dispatch handshake.
 fpu_wb_valid_i/fpu_wb_ready_o  in/out  1; fpu_wb_rd_i  in  5; fpu_wb_fp_i  in  1  FPU result.
 lsu_wb_valid_i  in  1; lsu_wb_rd_i  in  5; lsu_wb_we_i  in  1  memory result, always accepted.
 fpr_we_o  out  1; fpr_waddr_o  out  5  FP register-file write.
 fwd_sel_o  out  3x2  per-operand forward select: 0 none, 1 FPU, 2 LSU.
 inflight_cnt_o  out  4  instructions in flight; busy_o  out  1  inflight_cnt_o != 0.

Function
REQ-005 commit_valid_i & ~commit_kill_i SHALL set committed[commit_id_i]; commit_valid_i & commit_kill_i SHALL set killed[commit_id_i].
REQ-006 A commit to iss_id_i in the same cycle SHALL count as committed for that cycle (bypass).
REQ-007 Head killed: iss_ready_o=1 with no dispatch; the entry's committed/killed bits SHALL clear at that edge.
REQ-008 Hazard: any operand with iss_rs_used_i[k] & pending[iss_rs_i[k]] & fwd_sel_o[k]==0; or iss_rd_fp_i & pending[iss_rd_i] not cleared this cycle.
REQ-009 Dispatch-eligible = iss_valid_i & committed & ~hazard & inflight_cnt_o<MAX_INFLIGHT (credit freed this cycle SHALL NOT count); with OUT_OF_ORDER=0, additionally inflight_cnt_o==0 or a write-back this cycle.
REQ-010 Eligible & ~iss_is_mem_i SHALL raise fpu_in_valid_o; eligible & iss_is_mem_i SHALL raise mem_req_valid_o; never both.
REQ-011 iss_ready_o SHALL equal either dispatch handshake or the REQ-007 kill drop; on handshake committed[iss_id_i] SHALL clear.
REQ-012 pending[iss_rd_i] SHALL set on FPU handshake with iss_rd_fp_i, or memory handshake with iss_is_load_i.
REQ-013 fpu_wb_ready_o SHALL be ~lsu_wb_valid_i (LSU wins when both are valid).
REQ-014 Accepted FPU write-back with fpu_wb_fp_i, or LSU write-back with lsu_wb_we_i, SHALL drive fpr_we_o=1 and fpr_waddr_o combinationally and clear pending at that address; a same-cycle set of the same address SHALL win.
REQ-015 inflight_cnt_o: +1 per dispatch handshake, -1 per accepted FPU write-back or LSU write-back; both in one cycle leaves it unchanged; SHALL never exceed MAX_INFLIGHT or underflow.

Reset
REQ-016 rst_i high SHALL asynchronously clear pending, committed, killed and the counter; every output SHALL read 0 during reset, including fpu_wb_ready_o regardless of inputs.
REQ-017 Reset mid-operation SHALL discard all in-flight bookkeeping; results returned after release SHALL NOT underflow the counter.

Configuration
REQ-018 Macro FPU_SS_FORWARDING_EN defined: fwd_sel_o[k]=2 if the LSU write-back matches iss_rs_i[k], else 1 if the accepted FPU write-back matches, else 0; only when iss_rs_used_i[k].
REQ-019 Macro undefined: fwd_sel_o SHALL be tied to 0, and pending sources stall until the write-back edge has passed.

Structure
REQ-020 fwd_sel_e (NONE/FPU/LSU) and the counter width SHALL reside in fpu_ss_pkg.
REQ-021 The per-ID committed/killed table SHALL be sub-module fpu_ss_id_table (set/clear/query ports).

Verification
REQ-022 Commit ID 3 same cycle as head ID 3, rs clear, fpu_in_ready_i=1 -> fpu_in_valid_o=1 and iss_ready_o=1 in that cycle.
REQ-023 Kill ID 5, head reaches ID 5 -> iss_ready_o=1 with fpu_in_valid_o=0, mem_req_valid_o=0 and inflight_cnt_o unchanged.
REQ-024 MAX_INFLIGHT=2, two dispatches, third committed head -> stalls until a write-back; counter reads 2 then 1, then 2 after the refill dispatch.
REQ-025 FPU and LSU write-back same cycle, rd 7 and rd 9 -> fpu_wb_ready_o=0, fpr_waddr_o=9; the next cycle fpr_waddr_o=7.
REQ-026 Forwarding enabled, head rs 4 pending, FPU write-back to rd 4 -> fwd_sel_o=1 and dispatch in the same cycle; disabled -> dispatch one cycle later.
REQ-027 Assert rst_i with 3 in flight -> all outputs 0 immediately; after release a stale write-back leaves inflight_cnt_o at 0.
